// File: rtl/card_sprite_server_pkg.sv
// Shared types and constants for the card sprite server (package card_pkg).
// Sprite geometry, ROM layout and the load-source classification live here.
package card_pkg;

   localparam int SPR_W          = 56;
   localparam int SPR_H          = 80;
   localparam int SPR_WORDS      = SPR_W * SPR_H;
   localparam int CARDS_PER_SUIT = 13;
   localparam int ROM_AW         = 18;
   localparam int PIX_AW         = 13;
   localparam logic [11:0] FILL_RGB = 12'h0F0;

   typedef enum logic [1:0] {SUIT_CLUBS, SUIT_DIAMONDS, SUIT_HEARTS, SUIT_SPADES} suit_t;
   typedef logic [3:0]  rank_t;
   typedef logic [11:0] rgb_t;

   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, PEND_SWAP} srv_state_t;
   typedef enum logic [1:0] {SRC_ROM, SRC_FILL, SRC_BACK} src_t;

   // First ROM word of a face; only meaningful for ranks 1..13.
   function automatic logic [ROM_AW-1:0] face_base(suit_t suit, rank_t rank);
      logic [ROM_AW-1:0] face_idx;
      face_idx = ROM_AW'(suit) * ROM_AW'(CARDS_PER_SUIT) + ROM_AW'(rank) - ROM_AW'(1);
      return face_idx * ROM_AW'(SPR_WORDS);
   endfunction

endpackage

// File: rtl/card_sprite_server_if.sv
// Sprite server bus: card load request, frame sync, draw-stage pixel read and card-face ROM port.
// master = game logic / draw stage / ROM side, slave = the sprite server.
interface card_sprite_server_if;
   import card_pkg::*;

   logic              card_req_valid;
   rank_t             card_rank;
   suit_t             card_suit;
   logic              card_req_ready;
   logic              busy;
   logic              frame_start;
   logic [PIX_AW-1:0] pixel_addr;
   rgb_t              rgb_pixel;
   logic [ROM_AW-1:0] rom_addr;
   rgb_t              rom_data;

   modport master (
      output card_req_valid, card_rank, card_suit, frame_start, pixel_addr, rom_data,
      input  card_req_ready, busy, rgb_pixel, rom_addr
   );

   modport slave (
      input  card_req_valid, card_rank, card_suit, frame_start, pixel_addr, rom_data,
      output card_req_ready, busy, rgb_pixel, rom_addr
   );

endinterface

// File: rtl/card_sprite_server_sprite_buf.sv
// One 4480x12 sprite buffer: single write port, single read port, registered read data.
module sprite_buf
   import card_pkg::*;
(
   input  logic              clk,
   input  logic              we_i,
   input  logic [PIX_AW-1:0] waddr_i,
   input  rgb_t              wdata_i,
   input  logic [PIX_AW-1:0] raddr_i,
   output rgb_t              rdata_o
);

   rgb_t mem_q [SPR_WORDS];
   rgb_t rdata_q;

   // NOTE: the array and its read register carry no reset so they map onto block RAM.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/card_sprite_server.sv
// Ping-pong 56x80 sprite server: copies a card face from ROM into the shadow buffer and swaps
// buffers on frame_start. Define CARD_BACK_EN to draw a procedural card back for rank 0.
module card_sprite_server
   import card_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   card_sprite_server_if.slave  bus
);

   srv_state_t        state_q, state_d;
   src_t              src_q, src_d;
   logic [ROM_AW-1:0] base_q, base_d;
   logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
   logic [PIX_AW-1:0] offset_q, offset_d;
   logic              busy_q, busy_d;
   logic              active_q, active_d;
   logic              req_ready;
   logic              wr_en;
   logic [PIX_AW-1:0] wr_addr;
   rgb_t              wr_data;
   logic [1:0]        buf_we;
   rgb_t              rdata [2];
   logic              rd_sel_q, rd_oob_q, rd_vld_q;

   function automatic src_t rank_source(rank_t rank);
      if (rank > rank_t'(CARDS_PER_SUIT)) return SRC_FILL;
      if (rank == '0) begin
`ifdef CARD_BACK_EN
         return SRC_BACK;
`else
         return SRC_FILL;
`endif
      end
      return SRC_ROM;
   endfunction

`ifdef CARD_BACK_EN
   logic [5:0] x_q, x_d;
   logic [6:0] y_q, y_d;

   function automatic rgb_t back_pixel(logic [5:0] x, logic [6:0] y);
      if (x < 6'd2 || x >= 6'(SPR_W - 2) || y < 7'd2 || y >= 7'(SPR_H - 2)) return 12'hFFF;
      return (x[3] ^ y[3]) ? 12'hC00 : 12'h800;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end
`endif

   // NOTE: every signal gets a default before the case so no latches are inferred.
   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      base_d     = base_q;
      rom_addr_d = rom_addr_q;
      offset_d   = offset_q;
      busy_d     = busy_q;
      active_d   = active_q;
      req_ready  = 1'b0;
      wr_en      = 1'b0;
      wr_addr    = offset_q - PIX_AW'(1);
`ifdef CARD_BACK_EN
      x_d = x_q;
      y_d = y_q;
`endif
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (bus.card_req_valid) begin
               src_d    = rank_source(bus.card_rank);
               base_d   = face_base(bus.card_suit, bus.card_rank);
               busy_d   = 1'b1;
               offset_d = '0;
               state_d  = LOAD;
               if (rank_source(bus.card_rank) != SRC_ROM) rom_addr_d = '0;
`ifdef CARD_BACK_EN
               x_d = '0;
               y_d = '0;
`endif
            end
         end
         LOAD: begin
            rom_addr_d = (src_q == SRC_ROM) ? base_q + ROM_AW'(offset_q) : '0;
            wr_en      = (offset_q != '0);
            offset_d   = offset_q + PIX_AW'(1);
            if (offset_q == PIX_AW'(SPR_WORDS - 1)) state_d = FLUSH;
         end
         FLUSH: begin
            wr_en   = 1'b1;
            state_d = PEND_SWAP;
         end
         PEND_SWAP: begin
            if (bus.frame_start) begin
               active_d = ~active_q;
               busy_d   = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef CARD_BACK_EN
      if (wr_en) begin
         if (x_q == 6'(SPR_W - 1)) begin
            x_d = '0;
            y_d = y_q + 7'd1;
         end else begin
            x_d = x_q + 6'd1;
         end
      end
`endif
   end

   always_comb begin
      case (src_q)
         SRC_ROM:  wr_data = bus.rom_data;
`ifdef CARD_BACK_EN
         SRC_BACK: wr_data = back_pixel(x_q, y_q);
`endif
         default:  wr_data = FILL_RGB;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         src_q      <= SRC_ROM;
         base_q     <= '0;
         rom_addr_q <= '0;
         offset_q   <= '0;
         busy_q     <= 1'b0;
         active_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         base_q     <= base_d;
         rom_addr_q <= rom_addr_d;
         offset_q   <= offset_d;
         busy_q     <= busy_d;
         active_q   <= active_d;
      end
   end

   // Read select is captured with the address, so a swap only affects reads issued after it.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_sel_q <= 1'b0;
         rd_oob_q <= 1'b0;
         rd_vld_q <= 1'b0;
      end else begin
         rd_sel_q <= active_q;
         rd_oob_q <= (bus.pixel_addr >= PIX_AW'(SPR_WORDS));
         rd_vld_q <= 1'b1;
      end
   end

   assign buf_we[0] = wr_en &  active_q;
   assign buf_we[1] = wr_en & ~active_q;

   for (genvar i = 0; i < 2; i++) begin : g_buf
      sprite_buf u_buf (
         .clk     (clk),
         .we_i    (buf_we[i]),
         .waddr_i (wr_addr),
         .wdata_i (wr_data),
         .raddr_i (bus.pixel_addr),
         .rdata_o (rdata[i])
      );
   end

   assign bus.rgb_pixel      = (rd_vld_q && !rd_oob_q) ? rdata[rd_sel_q] : '0;
   assign bus.card_req_ready = req_ready;
   assign bus.busy           = busy_q;
   assign bus.rom_addr       = rom_addr_q;

endmodule
